// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one W-bit MSB-first magnitude comparator among N requesters.
// Define CMP_ARB_STATS_EN to add the 16-bit saturating ops_cnt output.
module cmp_share_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 4,
    parameter int unsigned PW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  a_in,
    input  logic [N*W-1:0]  b_in,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            a_lt_b,
    output logic            a_gt_b,
    output logic            a_eq_b,
`ifdef CMP_ARB_STATS_EN
    output logic [15:0]     ops_cnt,
`endif
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   owner_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [N-1:0]    done_q;
    logic            lt_q;
    logic            gt_q;
    logic            eq_q;

    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [N-1:0]    owner_oh;
    logic            lt_d;
    logic            gt_d;
    logic            eq_d;
    logic            hi_eq;

    // Two passes give the rotating priority: indices above ptr first, then wrap to 0..ptr.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_valid && req[i] && (PW'(i) > ptr_q)) begin
                win_valid = 1'b1;
                win_idx   = PW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_valid && req[i] && (PW'(i) <= ptr_q)) begin
                win_valid = 1'b1;
                win_idx   = PW'(i);
            end
        end
    end

    always_comb begin
        gnt      = '0;
        owner_oh = '0;
        a_sel    = '0;
        b_sel    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            gnt[i]      = (state_q == IDLE) && win_valid && (win_idx == PW'(i));
            owner_oh[i] = (owner_q == PW'(i));
            if (win_idx == PW'(i)) begin
                a_sel = a_in[i*W +: W];
                b_sel = b_in[i*W +: W];
            end
        end
    end

    // Cascade from MSB: a bit decides only while every higher bit pair was equal.
    always_comb begin
        hi_eq = 1'b1;
        lt_d  = 1'b0;
        gt_d  = 1'b0;
        for (int unsigned j = 0; j < W; j++) begin
            lt_d  = lt_d | (hi_eq & ~a_q[W-1-j] &  b_q[W-1-j]);
            gt_d  = gt_d | (hi_eq &  a_q[W-1-j] & ~b_q[W-1-j]);
            hi_eq = hi_eq & (a_q[W-1-j] ~^ b_q[W-1-j]);
        end
        eq_d = hi_eq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(N-1);
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= '0;
                    if (win_valid) begin
                        a_q     <= a_sel;
                        b_q     <= b_sel;
                        owner_q <= win_idx;
                        ptr_q   <= win_idx;
                        state_q <= CMP;
                    end
                end
                CMP: begin
                    lt_q    <= lt_d;
                    gt_q    <= gt_d;
                    eq_q    <= eq_d;
                    done_q  <= owner_oh;
                    state_q <= RESP;
                end
                RESP: begin
                    done_q  <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign a_lt_b = lt_q;
    assign a_gt_b = gt_q;
    assign a_eq_b = eq_q;
    assign busy   = (state_q != IDLE);

`ifdef CMP_ARB_STATS_EN
    logic [15:0] ops_cnt_q;
    logic [15:0] ops_cnt_d;

    always_comb begin
        ops_cnt_d = ops_cnt_q;
        if ((state_q == RESP) && (ops_cnt_q != '1)) begin
            ops_cnt_d = ops_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_cnt_q <= '0;
        end else begin
            ops_cnt_q <= ops_cnt_d;
        end
    end

    assign ops_cnt = ops_cnt_q;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter (N=4, W=4); ops_cnt checks build only with CMP_ARB_STATS_EN.
module tb_cmp_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        a_lt_b;
    logic        a_gt_b;
    logic        a_eq_b;
    logic        busy;
`ifdef CMP_ARB_STATS_EN
    logic [15:0] ops_cnt;
`endif

    int total;
    int bad;

    cmp_share_arbiter #(.N(4), .W(4), .PW(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .gnt    (gnt),
        .done   (done),
        .a_lt_b (a_lt_b),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
`ifdef CMP_ARB_STATS_EN
        .ops_cnt(ops_cnt),
`endif
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  r;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  e_gnt;
        logic [3:0]  e_done;
        logic [2:0]  e_flags;
        logic        e_busy;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [3:0] a, input logic [3:0] b);
        return {a < b, a > b, a == b};
    endfunction

    task automatic step(input logic [3:0] r);
        @(posedge clk);
        #2;
        req = r;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = 4'h0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #2;
    endtask

    initial begin
        logic [3:0] ea;
        logic [3:0] eb;
        int unsigned exp_i;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'h0;
        a_in  = '0;
        b_in  = '0;

        //          rst   req    a_in      b_in      gnt    done   {lt,gt,eq} busy
        vecs[0]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 3'b000, 1'b0};
        vecs[1]  = '{1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 3'b000, 1'b0};
        vecs[2]  = '{1'b1, 4'h1, 16'h0003, 16'h0009, 4'h1, 4'h0, 3'b000, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 16'h000F, 16'h0000, 4'h0, 4'h0, 3'b000, 1'b1};
        vecs[4]  = '{1'b1, 4'h0, 16'h000F, 16'h0000, 4'h0, 4'h1, 3'b100, 1'b1};
        vecs[5]  = '{1'b1, 4'h0, 16'h000F, 16'h0000, 4'h0, 4'h0, 3'b100, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 4'h0, 4'h0, 3'b000, 1'b0};
        vecs[7]  = '{1'b1, 4'h6, 16'h0F70, 16'h0070, 4'h2, 4'h0, 3'b000, 1'b0};
        vecs[8]  = '{1'b1, 4'h4, 16'h0F70, 16'h0070, 4'h0, 4'h0, 3'b000, 1'b1};
        vecs[9]  = '{1'b1, 4'h4, 16'h0F70, 16'h0070, 4'h0, 4'h2, 3'b001, 1'b1};
        vecs[10] = '{1'b1, 4'h4, 16'h0F70, 16'h0070, 4'h4, 4'h0, 3'b001, 1'b0};
        vecs[11] = '{1'b1, 4'h0, 16'h0F70, 16'h0070, 4'h0, 4'h0, 3'b001, 1'b1};
        vecs[12] = '{1'b1, 4'h0, 16'h0F70, 16'h0070, 4'h0, 4'h4, 3'b010, 1'b1};
        vecs[13] = '{1'b1, 4'h0, 16'h0F70, 16'h0070, 4'h0, 4'h0, 3'b010, 1'b0};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #2;
            rst_n = vecs[i].rst;
            req   = vecs[i].r;
            a_in  = vecs[i].a;
            b_in  = vecs[i].b;
            #2;
            chk($sformatf("v%0d gnt", i),   32'(gnt),  32'(vecs[i].e_gnt));
            chk($sformatf("v%0d done", i),  32'(done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d flags", i), 32'({a_lt_b, a_gt_b, a_eq_b}), 32'(vecs[i].e_flags));
            chk($sformatf("v%0d busy", i),  32'(busy), 32'(vecs[i].e_busy));
        end

        // All four requesting continuously: rotation 0,1,2,3,0,... from reset pointer.
        a_in = 16'h29A4;
        b_in = 16'h29B1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = 4'h0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        req   = 4'hF;
        #2;
        for (int k = 0; k < 8; k++) begin
            exp_i = k % 4;
            ea = a_in[exp_i*4 +: 4];
            eb = b_in[exp_i*4 +: 4];
            if (k > 0) step(4'hF);
            chk($sformatf("rr%0d gnt", k), 32'(gnt), 32'(4'b1 << exp_i));
            step(4'hF);
            chk($sformatf("rr%0d cmp gnt", k), 32'(gnt), 32'(0));
            chk($sformatf("rr%0d cmp busy", k), 32'(busy), 32'(1));
            step(4'hF);
            chk($sformatf("rr%0d done", k), 32'(done), 32'(4'b1 << exp_i));
            chk($sformatf("rr%0d flags", k), 32'({a_lt_b, a_gt_b, a_eq_b}), 32'(ref_cmp(ea, eb)));
        end

        // Short req0 pulse during CMP must be ignored.
        a_in = 16'h0053;
        b_in = 16'h0035;
        do_reset();
        step(4'h2);
        chk("pulse gnt1", 32'(gnt), 32'(4'h2));
        step(4'h3);
        chk("pulse cmp gnt", 32'(gnt), 32'(0));
        step(4'h0);
        chk("pulse done1", 32'(done), 32'(4'h2));
        chk("pulse flags1", 32'({a_lt_b, a_gt_b, a_eq_b}), 32'(3'b010));
        step(4'h0);
        chk("pulse idle gnt", 32'(gnt), 32'(0));
        step(4'h0);
        chk("pulse no done", 32'(done), 32'(0));
        chk("pulse idle busy", 32'(busy), 32'(0));

        // Reset during CMP discards the operation.
        step(4'h2);
        chk("abort gnt", 32'(gnt), 32'(4'h2));
        step(4'h0);
        chk("abort cmp busy", 32'(busy), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort done", 32'(done), 32'(0));
        chk("abort busy", 32'(busy), 32'(0));
        chk("abort flags", 32'({a_lt_b, a_gt_b, a_eq_b}), 32'(0));
        step(4'h0);
        chk("abort held done", 32'(done), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        req   = 4'h3;
        #2;
        chk("abort regrant0", 32'(gnt), 32'(4'h1));
        step(4'h2);
        chk("abort cmp gnt", 32'(gnt), 32'(0));
        step(4'h2);
        chk("abort done0", 32'(done), 32'(4'h1));
        chk("abort flags0", 32'({a_lt_b, a_gt_b, a_eq_b}), 32'(3'b100));
        step(4'h2);
        chk("abort gnt1", 32'(gnt), 32'(4'h2));
        step(4'h0);
        step(4'h0);
        chk("abort done1", 32'(done), 32'(4'h2));
        chk("abort flags1", 32'({a_lt_b, a_gt_b, a_eq_b}), 32'(3'b010));

`ifdef CMP_ARB_STATS_EN
        do_reset();
        chk("cnt reset", 32'(ops_cnt), 32'(0));
        req = 4'hF;
        repeat (14) step(4'hF);
        step(4'h0);
        chk("cnt five", 32'(ops_cnt), 32'(5));
        force dut.ops_cnt_q = 16'hFFFE;
        step(4'h0);
        release dut.ops_cnt_q;
        repeat (6) step(4'h1);
        step(4'h0);
        chk("cnt saturate", 32'(ops_cnt), 32'(16'hFFFF));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
